// File: rtl/bist_pkg.sv
// Shared types for the BIST response checker: controller states and the read delay-pipe entry.
// Pipe entries are sized for the widest supported address/data; narrower instances zero-extend.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam int MAX_RD_LATENCY = 4;
    localparam int MAX_ADDR_WIDTH = 32;
    localparam int MAX_DATA_WIDTH = 64;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_DATA_WIDTH-1:0] exp;
    } bist_pipe_entry_t;

endpackage

// File: rtl/bist_rd_delay_pipe.sv
// Delays issued-read descriptors by RD_LATENCY cycles so they line up with returning memory data.
// Synchronous flush empties every stage; asynchronous reset does the same immediately.
module bist_rd_delay_pipe
    import bist_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  bist_pipe_entry_t entry_i,
    output bist_pipe_entry_t entry_o
);

    bist_pipe_entry_t stage_q [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= entry_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign entry_o = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/bist_response_checker.sv
// Compares returning memory read data against BIST expected data and reports pass/fail results.
// Optional BIST_FAIL_SYNDROME_EN adds fail_bits, the OR of all mismatch syndromes since start.
module bist_response_checker
    import bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     NbarT,
    input  logic                     start,
    input  logic                     test_end,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    bist_addr,
    input  logic [DATA_WIDTH-1:0]    exp_data,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic [DATA_WIDTH-1:0]    fail_data,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
`ifdef BIST_FAIL_SYNDROME_EN
    ,
    output logic [DATA_WIDTH-1:0]    fail_bits
`endif
);

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LATENCY - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

    bist_state_e state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic        clear, flush;

    logic                     busy_q, done_q, fail_q;
    logic [ADDR_WIDTH-1:0]    fail_addr_q;
    logic [DATA_WIDTH-1:0]    fail_data_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    bist_pipe_entry_t pipe_in, pipe_out;
    logic             mismatch;
    logic             unused_pipe_addr;

    // Abort on NbarT dropping takes priority over a restart, which in turn beats test_end.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        clear       = 1'b0;
        flush       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && NbarT) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (!NbarT) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (start) begin
                    clear = 1'b1;
                end else if (test_end) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!NbarT) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (start && NbarT) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            flush = 1'b1;
        end
    end

    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = rd_en & NbarT & (state_q == RUN);
        pipe_in.addr  = MAX_ADDR_WIDTH'(bist_addr);
        pipe_in.exp   = MAX_DATA_WIDTH'(exp_data);
    end

    bist_rd_delay_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_delay_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .entry_i (pipe_in),
        .entry_o (pipe_out)
    );

    // Addresses beyond ADDR_WIDTH are always zero in the pipe.
    assign unused_pipe_addr = ^pipe_out.addr;

    assign mismatch = pipe_out.valid & NbarT &
                      (MAX_DATA_WIDTH'(mem_rdata) != pipe_out.exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= (state_d == RUN) || (state_d == DRAIN);
            done_q      <= (state_d == DONE);
            if (clear) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
                err_cnt_q   <= '0;
            end else if (mismatch) begin
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= pipe_out.addr[ADDR_WIDTH-1:0];
                    fail_data_q <= mem_rdata;
                end
                if (err_cnt_q != ERR_CNT_MAX) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef BIST_FAIL_SYNDROME_EN
    logic [DATA_WIDTH-1:0] fail_bits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_bits_q <= '0;
        end else if (clear) begin
            fail_bits_q <= '0;
        end else if (mismatch) begin
            fail_bits_q <= fail_bits_q | (mem_rdata ^ pipe_out.exp[DATA_WIDTH-1:0]);
        end
    end

    assign fail_bits = fail_bits_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bist_response_checker.sv
// Bench for bist_response_checker: directed test phases with random data, checked every cycle
// against a queue-based model of issued reads and test progress.
module tb_bist_response_checker;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int L  = 3;
    localparam int EW = 3;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          NbarT = 1'b0;
    logic          start = 1'b0;
    logic          test_end = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] bist_addr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [EW-1:0] err_cnt;
`ifdef BIST_FAIL_SYNDROME_EN
    logic [DW-1:0] fail_bits;
`endif

    bist_response_checker #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .RD_LATENCY    (L),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .NbarT     (NbarT),
        .start     (start),
        .test_end  (test_end),
        .rd_en     (rd_en),
        .bist_addr (bist_addr),
        .exp_data  (exp_data),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_cnt   (err_cnt)
`ifdef BIST_FAIL_SYNDROME_EN
        ,
        .fail_bits (fail_bits)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] xd;
        int            due;
    } rd_t;

    rd_t           pend[$];
    int            cyc;
    bit            m_run, m_drain, m_done;
    int            m_done_at;
    bit            m_fail;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fdata;
    int            m_errs;
    logic [DW-1:0] m_bits;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_results();
        m_fail  = 1'b0;
        m_faddr = '0;
        m_fdata = '0;
        m_errs  = 0;
        m_bits  = '0;
    endtask

    task automatic model_reset();
        pend.delete();
        m_run   = 1'b0;
        m_drain = 1'b0;
        m_done  = 1'b0;
        clear_results();
    endtask

    task automatic check_all();
        chk("busy", 64'(busy), 64'(m_run || m_drain));
        chk("done", 64'(done), 64'(m_done));
        chk("fail", 64'(fail), 64'(m_fail));
        chk("fail_addr", 64'(fail_addr), 64'(m_faddr));
        chk("fail_data", 64'(fail_data), 64'(m_fdata));
        chk("err_cnt", 64'(err_cnt), 64'((m_errs > ERR_MAX) ? ERR_MAX : m_errs));
`ifdef BIST_FAIL_SYNDROME_EN
        chk("fail_bits", 64'(fail_bits), 64'(m_bits));
`endif
    endtask

    // Predicts the effect of the current cycle's inputs at the coming clock edge.
    task automatic model_step();
        rd_t r;
        if ((m_run || m_drain) && !NbarT) begin
            m_run   = 1'b0;
            m_drain = 1'b0;
            pend.delete();
        end else if (start && NbarT) begin
            clear_results();
            pend.delete();
            m_run   = 1'b1;
            m_drain = 1'b0;
            m_done  = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                if (mem_rdata !== r.xd) begin
                    if (!m_fail) begin
                        m_fail  = 1'b1;
                        m_faddr = r.addr;
                        m_fdata = mem_rdata;
                    end
                    m_errs++;
                    m_bits = m_bits | (mem_rdata ^ r.xd);
                end
            end
            if (m_run && rd_en) begin
                r.addr = bist_addr;
                r.xd   = exp_data;
                r.due  = cyc + L;
                pend.push_back(r);
            end
            if (m_run && test_end) begin
                m_run     = 1'b0;
                m_drain   = 1'b1;
                m_done_at = cyc + L + 1;
            end
            if (m_drain && (cyc + 1 == m_done_at)) begin
                m_drain = 1'b0;
                m_done  = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs at negedge, returned data corrupted with probability pct%.
    task automatic step(input bit st, input bit te, input bit rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit nb, input int pct);
        int idx;
        logic [DW-1:0] flip;
        @(negedge clk);
        start     = st;
        test_end  = te;
        rd_en     = rd;
        bist_addr = a;
        exp_data  = d;
        NbarT     = nb;
        idx = -1;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) idx = i;
        end
        if (idx >= 0) begin
            flip = DW'($urandom_range(1, (1 << DW) - 1));
            if (int'($urandom_range(0, 99)) < pct) mem_rdata = pend[idx].xd ^ flip;
            else mem_rdata = pend[idx].xd;
        end else begin
            mem_rdata = DW'($urandom);
        end
        model_step();
        @(posedge clk);
        #1;
        check_all();
        cyc++;
    endtask

    task automatic idle(input int n, input bit nb, input int pct);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0, nb, pct);
    endtask

    task automatic rnd_rd(input bit te, input int pct);
        step(1'b0, te, 1'b1, AW'($urandom), DW'($urandom), 1'b1, pct);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1, 1'b1, 0);

        // Clean run: four reads of 0xA5, test_end on the last read, then drain.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        for (int i = 0; i < 4; i++) step(1'b0, i == 3, 1'b1, AW'(i), 8'hA5, 1'b1, 0);
        idle(L + 2, 1'b1, 0);

        // Random reads with random corruption.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), 1'b1, 40);
        end
        rnd_rd(1'b1, 40);
        idle(L + 2, 1'b1, 40);

        // test_end coincident with the last read; its data is bad during DRAIN.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 8'h10, 8'h3C, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 8'h7F, 8'hC3, 1'b1, 0);
        idle(2, 1'b1, 0);
        idle(1, 1'b1, 100);
        idle(2, 1'b1, 0);

        // Error counter saturation, then rd_en while DONE is ignored.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        for (int i = 0; i < 10; i++) rnd_rd(i == 9, 100);
        idle(L + 1, 1'b1, 100);
        for (int i = 0; i < L + 2; i++) rnd_rd(1'b0, 100);

        // Abort mid-RUN with reads in flight, idle in normal mode, then restart clears results.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        for (int i = 0; i < 5; i++) rnd_rd(1'b0, 100);
        idle(4, 1'b0, 100);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 8'h22, 8'h33, 1'b1, 0);
        for (int i = 0; i < 3; i++) rnd_rd(i == 2, 0);
        idle(L + 1, 1'b1, 0);

        // Restart while draining, with a read in the start cycle that must be dropped.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        for (int i = 0; i < 3; i++) rnd_rd(i == 2, 100);
        idle(1, 1'b1, 100);
        step(1'b1, 1'b0, 1'b1, 8'h44, 8'h55, 1'b1, 100);
        for (int i = 0; i < 4; i++) rnd_rd(i == 3, 50);
        idle(L + 1, 1'b1, 50);

        // Asynchronous reset in the middle of a failing run.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        for (int i = 0; i < 6; i++) rnd_rd(1'b0, 100);
        #2;
        rst_n    = 1'b0;
        start    = 1'b0;
        rd_en    = 1'b0;
        test_end = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1, 0);

        // Short clean run after reset.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 0);
        for (int i = 0; i < 3; i++) rnd_rd(i == 2, 30);
        idle(L + 1, 1'b1, 30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
